// File: rtl/cam_read.sv
// cam_read: captures a camera byte stream into frame-buffer pixel writes.
// Two bytes per pixel, one write pulse per pixel, capture starts only after a
// full vsync high-then-low sequence. Define RGB565_EN to take RGB565 input and
// truncate it to RGB444; the default build takes RGB444 input.
module cam_read #(
   parameter int unsigned AW       = 15,
   parameter int unsigned DW       = 12,
   parameter int unsigned IMA_SIZE = 19200
) (
   input  logic          clk_w,
   input  logic          reset,
   input  logic          vsync,
   input  logic          href,
   input  logic [7:0]    px_data,
   output logic [AW-1:0] addr_in,
   output logic [DW-1:0] data_in,
   output logic          regwrite,
   output logic          frame_done
);

   localparam int unsigned PIX_W = 12;
`ifdef RGB565_EN
   // Keeps R[4:1] and G[5:3] of the first byte.
   localparam int unsigned HI_W  = 7;
`else
   // Keeps R[3:0] of the first byte.
   localparam int unsigned HI_W  = 4;
`endif

   typedef enum logic [1:0] {
      INIT       = 2'd0,
      WAIT_FRAME = 2'd1,
      BYTE1      = 2'd2,
      BYTE2      = 2'd3
   } state_t;

   state_t            state_q;
   logic [AW-1:0]     cnt_q;
   logic [HI_W-1:0]   hi_q;
   logic [HI_W-1:0]   hi_next_c;
   logic [PIX_W-1:0]  pix_c;
   logic              cnt_full_c;

   // Pixel packing: only the bits that survive into the 12-bit pixel are kept.
   always_comb begin
`ifdef RGB565_EN
      hi_next_c = {px_data[7:4], px_data[2:0]};
      pix_c     = {hi_q[6:3], hi_q[2:0], px_data[7], px_data[4:1]};
`else
      hi_next_c = px_data[3:0];
      pix_c     = {hi_q, px_data};
`endif
      cnt_full_c = (cnt_q == AW'(IMA_SIZE));
   end

   // Capture FSM with registered outputs; write pulses are single-cycle.
   always_ff @(posedge clk_w or negedge reset) begin
      if (!reset) begin
         state_q    <= INIT;
         cnt_q      <= '0;
         hi_q       <= '0;
         addr_in    <= '0;
         data_in    <= '0;
         regwrite   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         regwrite   <= 1'b0;
         frame_done <= 1'b0;
         case (state_q)
            // Never start mid-frame: wait for the first vsync high.
            INIT: begin
               if (vsync) state_q <= WAIT_FRAME;
            end
            WAIT_FRAME: begin
               if (!vsync) begin
                  cnt_q   <= '0;
                  state_q <= BYTE1;
               end
            end
            BYTE1: begin
               if (vsync) begin
                  frame_done <= 1'b1;
                  state_q    <= WAIT_FRAME;
               end else if (href) begin
                  hi_q    <= hi_next_c;
                  state_q <= BYTE2;
               end
            end
            BYTE2: begin
               if (vsync) begin
                  // Pending half pixel is dropped at end of frame.
                  frame_done <= 1'b1;
                  state_q    <= WAIT_FRAME;
               end else begin
                  // href low here means an odd byte count: drop the half pixel.
                  state_q <= BYTE1;
                  if (href && !cnt_full_c) begin
                     addr_in  <= cnt_q;
                     data_in  <= DW'(pix_c);
                     regwrite <= 1'b1;
                     cnt_q    <= cnt_q + AW'(1);
                  end
               end
            end
            default: state_q <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_cam_read.sv
// Self-checking bench for cam_read: random and directed byte streams are
// compared against a line/pixel level reference model of the capture rules.
module tb_cam_read;

   localparam int unsigned AW       = 15;
   localparam int unsigned DW       = 12;
   localparam int unsigned IMA_SIZE = 19200;

   typedef logic [7:0] byte_q_t[$];
   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   logic          clk_w = 1'b0;
   logic          reset;
   logic          vsync;
   logic          href;
   logic [7:0]    px_data;
   logic [AW-1:0] addr_in;
   logic [DW-1:0] data_in;
   logic          regwrite;
   logic          frame_done;

   cam_read #(.AW(AW), .DW(DW), .IMA_SIZE(IMA_SIZE)) dut (
      .clk_w(clk_w), .reset(reset), .vsync(vsync), .href(href),
      .px_data(px_data), .addr_in(addr_in), .data_in(data_in),
      .regwrite(regwrite), .frame_done(frame_done)
   );

   always #5 clk_w = ~clk_w;

   int  n_chk = 0;
   int  n_err = 0;
   wr_t obs_q[$];
   wr_t exp_q[$];
   int  exp_cnt = 0;
   int  fd_cnt  = 0;
   int  dbl_cnt = 0;
   logic prev_rw = 1'b0;

   // Records every write and frame_done cycle just after each active edge.
   always @(posedge clk_w) begin
      #1;
      if (regwrite === 1'b1) obs_q.push_back({addr_in, data_in});
      if (frame_done === 1'b1) fd_cnt++;
      if (regwrite === 1'b1 && prev_rw === 1'b1) dbl_cnt++;
      prev_rw = regwrite;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pixel colour rule taken straight from the camera byte formats.
   function automatic logic [DW-1:0] exp_pix(input logic [7:0] b1, input logic [7:0] b2);
`ifdef RGB565_EN
      return {b1[7:4], b1[2:0], b2[7], b2[4:1]};
`else
      return {b1[3:0], b2};
`endif
   endfunction

   // Model: a line yields floor(n/2) pixels at consecutive addresses, capped at IMA_SIZE.
   task automatic model_line(input byte_q_t b);
      for (int i = 0; i + 1 < b.size(); i += 2) begin
         if (exp_cnt < int'(IMA_SIZE)) begin
            exp_q.push_back({AW'(exp_cnt), exp_pix(b[i], b[i+1])});
            exp_cnt++;
         end
      end
   endtask

   task automatic tick_in(input logic v, input logic h, input logic [7:0] d);
      @(negedge clk_w);
      vsync = v; href = h; px_data = d;
   endtask

   task automatic send_bytes(input byte_q_t b, input int gap);
      foreach (b[i]) tick_in(1'b0, 1'b1, b[i]);
      for (int i = 0; i < gap; i++) tick_in(1'b0, 1'b0, 8'($urandom));
   endtask

   task automatic send_line(input byte_q_t b);
      model_line(b);
      send_bytes(b, 2);
   endtask

   function automatic byte_q_t rand_bytes(input int n);
      byte_q_t q;
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      return q;
   endfunction

   task automatic compare_frame(input string tag);
      int n;
      check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check({tag, "_addr"}, 32'(obs_q[i].a), 32'(exp_q[i].a));
         check({tag, "_data"}, 32'(obs_q[i].d), 32'(exp_q[i].d));
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic begin_frame();
      for (int i = 0; i < 3; i++) tick_in(1'b0, 1'b0, 8'h00);
      obs_q.delete(); exp_q.delete();
      exp_cnt = 0; fd_cnt = 0; dbl_cnt = 0;
   endtask

   task automatic end_frame(input string tag);
      for (int i = 0; i < 3; i++) tick_in(1'b1, 1'b0, 8'h00);
      check({tag, "_frame_done"}, 32'(fd_cnt), 32'd1);
      check({tag, "_regwrite_1cyc"}, 32'(dbl_cnt), 32'd0);
      compare_frame(tag);
   endtask

   initial begin
      byte_q_t b;
      logic [DW-1:0] last_d;
      vsync = 1'b0; href = 1'b0; px_data = 8'h00; reset = 1'b1;
      #2 reset = 1'b0;
      for (int i = 0; i < 3; i++) tick_in(1'b0, 1'b0, 8'h00);
      check("rst_addr", 32'(addr_in), 32'd0);
      check("rst_data", 32'(data_in), 32'd0);
      check("rst_regwrite", 32'(regwrite), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      reset = 1'b1;

      // Bytes with vsync never high since reset: nothing captured.
      send_bytes(rand_bytes(20), 2);
      check("init_no_write", 32'(obs_q.size()), 32'd0);
      check("init_addr", 32'(addr_in), 32'd0);
      check("init_data", 32'(data_in), 32'd0);
      check("init_frame_done", 32'(fd_cnt), 32'd0);
      for (int i = 0; i < 3; i++) tick_in(1'b1, 1'b0, 8'h00);
      check("sync_no_frame_done", 32'(fd_cnt), 32'd0);

      // Directed RGB444 pixels.
      begin_frame();
      b = '{8'h0F, 8'hA5, 8'h03, 8'hC1};
      send_line(b);
`ifndef RGB565_EN
      check("px0_const", 32'(obs_q.size() > 0 ? obs_q[0].d : '0), 32'h0FA5);
      check("px1_const", 32'(obs_q.size() > 1 ? obs_q[1].d : '0), 32'h03C1);
`endif
      end_frame("directed");

      // Odd-length line drops its trailing byte; next line continues addressing.
      begin_frame();
      send_line(rand_bytes(3));
      check("odd_one_write", 32'(obs_q.size()), 32'd1);
      send_line(rand_bytes(2));
      end_frame("odd_line");

      // Random frames of random-length lines.
      for (int f = 0; f < 3; f++) begin
         begin_frame();
         for (int l = 0; l < 6; l++) send_line(rand_bytes(int'($urandom_range(1, 40))));
         end_frame("random");
      end

      // Over-long frame: writes stop at IMA_SIZE-1, counter freezes.
      begin_frame();
      send_line(rand_bytes(2 * (int'(IMA_SIZE) + 10)));
      last_d = exp_q[exp_q.size()-1].d;
      check("long_count", 32'(obs_q.size()), 32'(IMA_SIZE));
      check("long_last_addr", 32'(obs_q.size() > 0 ? obs_q[obs_q.size()-1].a : '0), 32'(IMA_SIZE - 1));
      end_frame("long");
      check("long_hold_addr", 32'(addr_in), 32'(IMA_SIZE - 1));
      check("long_hold_data", 32'(data_in), 32'(last_d));

      // Reset mid-frame at pixel 500.
      begin_frame();
      b = rand_bytes(1000);
      model_line(b);
      send_bytes(b, 0);
      @(negedge clk_w);
      href = 1'b0;
      reset = 1'b0;
      #1;
      check("midrst_addr", 32'(addr_in), 32'd0);
      check("midrst_data", 32'(data_in), 32'd0);
      check("midrst_regwrite", 32'(regwrite), 32'd0);
      check("midrst_no_frame_done", 32'(fd_cnt), 32'd0);
      compare_frame("pre_reset");
      tick_in(1'b0, 1'b0, 8'h00);
      reset = 1'b1;
      send_bytes(rand_bytes(10), 2);
      check("postrst_no_write", 32'(obs_q.size()), 32'd0);
      for (int i = 0; i < 3; i++) tick_in(1'b1, 1'b0, 8'h00);
      check("postrst_sync_no_fd", 32'(fd_cnt), 32'd0);
      begin_frame();
      send_line(rand_bytes(8));
      check("postrst_first_addr", 32'(obs_q.size() > 0 ? obs_q[0].a : '1), 32'd0);
      end_frame("post_reset");

`ifdef RGB565_EN
      begin_frame();
      b = '{8'hF8, 8'h1F};
      send_line(b);
      check("rgb565_const", 32'(obs_q.size() > 0 ? obs_q[0].d : '0), 32'h0F0F);
      end_frame("rgb565");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
